tanh_interp_pipe: RTL and testbench

//  Piecewise-linear tanh evaluator stage that feeds the tanh LUT and consumes its outputs.
//  - Splits each signed activation sample x into a LUT address and a fraction.
//  - Drives the address to the combinational LUT, then reads back base/next__data.
//  - Interpolates y = base + ((next - base) * frac) >>> FRAC_W.
//  - Returns y over a valid/ready stream.

---
 rtl/tanh_interp_pipe.sv | 94 +++++++++
 tb/tb_tanh_interp_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_interp_pipe.sv
// Three-stage piecewise-linear tanh evaluator.
// S1 registers the sample as LUT address + fraction; S2 captures the LUT base and the
// slope*fraction product; S3 adds, saturates and presents the result on a valid/ready stream.
module tanh_interp_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] next__data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic [CNT_W-1:0]  out_count
);

  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int PROD_W = DATA_W + FRAC_W + 2;

  localparam logic signed [PROD_W-1:0] YMAX = PROD_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] YMIN = ~YMAX;

  logic                     adv;
  logic                     v1;
  logic                     v2;
  logic [ADDR_W-1:0]        a1;
  logic [FRAC_W-1:0]        f1;
  logic [DATA_W-1:0]        b2;
  logic signed [PROD_W-1:0] p2;

  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] diff_x;
  logic signed [PROD_W-1:0] frac_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] sum;
  logic [DATA_W-1:0]        y_sat;

  // All stages advance together whenever the output slot is free or being taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign address  = a1;

  // Slope times fraction at full width, then base plus floored quotient, clamped to DATA_W.
  always_comb begin
    diff   = $signed({next__data[DATA_W-1], next__data}) - $signed({base[DATA_W-1], base});
    diff_x = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
    frac_x = {{(PROD_W-FRAC_W){1'b0}}, f1};
    prod   = diff_x * frac_x;
    sum    = $signed({{(PROD_W-DATA_W){b2[DATA_W-1]}}, b2}) + (p2 >>> FRAC_W);
    if (sum > YMAX) begin
      y_sat = YMAX[DATA_W-1:0];
    end else if (sum < YMIN) begin
      y_sat = YMIN[DATA_W-1:0];
    end else begin
      y_sat = sum[DATA_W-1:0];
    end
  end

  // Pipeline registers and transfer counter; a stall freezes every stage including the address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      a1        <= '0;
      f1        <= '0;
      b2        <= '0;
      p2        <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_count <= '0;
    end else begin
      if (adv) begin
        v1        <= in_valid;
        a1        <= in_x[DATA_W-1:FRAC_W];
        f1        <= in_x[FRAC_W-1:0];
        v2        <= v1;
        b2        <= base;
        p2        <= prod;
        out_valid <= v2;
        out_y     <= y_sat;
      end
      if (out_valid && out_ready) begin
        out_count <= out_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tanh_interp_pipe.sv
// Bench for tanh_interp_pipe: models the tanh LUT, predicts each result from the sample
// value with plain integer arithmetic and scoreboards results in acceptance order.
module tb_tanh_interp_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [3:0] address;
  logic [7:0] base;
  logic [7:0] next__data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [15:0] out_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int cnt_exp = 0;
  bit lat_chk = 1'b1;
  string phase = "reset";

  typedef struct {
    int y;
    int cyc;
  } exp_t;
  exp_t q[$];

  int lut_tab [16] = '{0, 12, 15, 15, 15, 15, 15, 15, -15, -15, -15, -15, -15, -15, -15, -12};

  // LUT neighbour: holds at the positive end of the range, wraps from the last entry to entry 0.
  function automatic int nxt(input int a);
    return (a == 7) ? 7 : ((a + 1) % 16);
  endfunction

  assign base       = 8'(lut_tab[address]);
  assign next__data = 8'(lut_tab[nxt(int'(address))]);

  always #5 clk = ~clk;

  tanh_interp_pipe #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .address    (address),
    .base       (base),
    .next__data (next__data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_count  (out_count)
  );

  function automatic int model(input logic [7:0] x);
    int a, f, b, n, y;
    a = int'(x) / 16;
    f = int'(x) % 16;
    b = lut_tab[a];
    n = lut_tab[nxt(a)];
    y = b + (((n - b) * f) >>> 4);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, score any output transfer, record any acceptance.
  task automatic cycle(input logic iv, input logic [7:0] ix, input logic ordy, output logic acc);
    exp_t e;
    in_valid  = iv;
    in_x      = ix;
    out_ready = ordy;
    #1;
    if (out_valid === 1'b1) begin
      chk({phase, "_no_stale"}, (q.size() > 0) ? 1 : 0, 1);
      if (q.size() > 0) begin
        if (ordy) begin
          e = q.pop_front();
          chk({phase, "_y"}, $signed(out_y), e.y);
          if (lat_chk) chk({phase, "_latency"}, cyc - e.cyc, 3);
          cnt_exp++;
        end else begin
          chk({phase, "_hold"}, $signed(out_y), q[0].y);
        end
      end
    end
    acc = iv && (in_ready === 1'b1);
    if (acc) begin
      e.y   = model(ix);
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    cnt_exp = 0;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b1, acc);
    chk({phase, "_drained"}, q.size(), 0);
  endtask

  initial begin
    logic acc;
    int k;
    int c0;
    logic [7:0] xs [5];

    in_x = '0;
    do_reset();
    do_reset();
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_y", out_y, 0);
    chk("reset_address", address, 0);
    chk("reset_out_count", out_count, 0);
    chk("reset_in_ready", in_ready, 1);

    // Single samples, then saturating entries and wrap.
    phase = "single";
    xs[0] = 8'h00; xs[1] = 8'h08; xs[2] = 8'h18; xs[3] = 8'h7F; xs[4] = 8'h88;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, xs[i], 1'b1, acc);
      for (int j = 0; j < 4; j++) cycle(1'b0, 8'h00, 1'b1, acc);
    end
    phase = "wrap";
    cycle(1'b1, 8'hF8, 1'b1, acc);
    cycle(1'b1, 8'hF1, 1'b1, acc);
    drain();

    // Back-to-back full sweep of LUT addresses.
    phase = "stream";
    c0 = cnt_exp;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i * 16), 1'b1, acc);
    drain();
    chk("stream_count_delta", int'(out_count) - c0, 16);
    chk("stream_count", out_count, cnt_exp);

    // Backpressure: 3 accepted before the stall propagates back to the input.
    phase = "bp";
    lat_chk = 1'b0;
    xs[0] = 8'h08; xs[1] = 8'h18; xs[2] = 8'hF8; xs[3] = 8'h7F; xs[4] = 8'hF1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(k < 5, xs[k % 5], 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_accepted", k, 3);
    #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 20 && (k < 5 || q.size() > 0); i++) begin
      cycle(k < 5, xs[k % 5], 1'b1, acc);
      if (acc) k++;
    end
    chk("bp_all_accepted", k, 5);
    chk("bp_drained", q.size(), 0);
    chk("bp_count", out_count, cnt_exp);

    // Randomized traffic with random backpressure.
    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, acc);
    end
    drain();
    chk("rand_count", out_count, cnt_exp);

    // Reset with samples in flight.
    phase = "midreset";
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b1, acc);
    do_reset();
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_count", out_count, 0);
    chk("midreset_address", address, 0);
    chk("midreset_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, acc);
    chk("midreset_quiet", out_valid, 0);

    // Counter wrap after 2^16 transfers.
    phase = "cnt";
    for (int i = 0; i < 65535; i++) cycle(1'b1, 8'($urandom), 1'b1, acc);
    drain();
    chk("cnt_max", out_count, 65535);
    cycle(1'b1, 8'h18, 1'b1, acc);
    drain();
    chk("cnt_wrap0", out_count, 0);
    cycle(1'b1, 8'h88, 1'b1, acc);
    drain();
    chk("cnt_wrap1", out_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
